prbs5_checker: RTL and testbench

- Receive end of the 5-bit PRBS link: checks a serial bit stream produced by the team's 5-bit LFSR generator.
- Generator: taps x^5+x^2+1, all-ones seed, serial bit = state MSB, period 31.
- Self-synchronises to the stream from the received bits, then flywheels a local predictor and counts bit errors.
- Sits at the consumer side of BIST/link-test paths.

---
 rtl/prbs5_checker.sv | 157 +++++++++++++++
 tb/tb_prbs5_checker.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs5_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs5_checker
// Description : Receive-side checker for the 5-bit PRBS link (x^5+x^2+1,
//               period 31). It self-synchronises a 5-bit history from the
//               received bits, then flywheels a local predictor and counts
//               mismatches. A burst of errors within one window drops lock
//               and restarts the search.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-high reset
//               bit_in     - received serial bit
//               bit_valid  - bit_in is sampled on this edge; low holds state
//               clr_cnt    - synchronous clear of err_cnt and bit_cnt
//               locked     - checker is in the LOCKED state
//               err_pulse  - previous sampled bit mismatched while locked
//               err_cnt    - saturating mismatch count while locked
//               bit_cnt    - saturating checked-bit count while locked
// Revision    : 1.0 - initial release
// ============================================================================
module prbs5_checker #(
    parameter int LOCK_CNT  = 8,
    parameter int ERR_LIMIT = 4,
    parameter int WIN       = 31,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    // Window position and window-error count both need to hold 0..WIN.
    localparam int WCW = $clog2(WIN + 1);

    localparam logic [7:0]       c_lock_cnt  = 8'(LOCK_CNT);
    localparam logic [WCW-1:0]   c_win_last  = WCW'(WIN - 1);
    localparam logic [WCW-1:0]   c_err_limit = WCW'(ERR_LIMIT);
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;
    localparam logic [2:0]       c_fill_full = 3'd5;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t         r_state;
    logic [4:0]     r_hist;   // r_hist[k] = y(n-1-k)
    logic [2:0]     r_fill;
    logic [7:0]     r_match;
    logic [WCW-1:0] r_wcnt;
    logic [WCW-1:0] r_werr;

    logic           w_pred;
    logic           w_mism;
    logic [7:0]     w_match_inc;
    logic [WCW-1:0] w_werr_inc;

    // y(n) = y(n-3) ^ y(n-5)
    assign w_pred      = r_hist[2] ^ r_hist[4];
    assign w_mism      = bit_in ^ w_pred;
    assign w_match_inc = r_match + 8'd1;
    // Cannot overflow: r_werr stays below ERR_LIMIT <= WIN.
    assign w_werr_inc  = r_werr + WCW'(w_mism);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_SEARCH;
            r_hist    <= 5'b00000;
            r_fill    <= 3'd0;
            r_match   <= 8'd0;
            r_wcnt    <= '0;
            r_werr    <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;

            if (bit_valid) begin
                case (r_state)
                    ST_SEARCH: begin
                        r_hist <= {r_hist[3:0], bit_in};
                        if (r_fill != c_fill_full) begin
                            r_fill <= r_fill + 3'd1;
                        end else if (!w_mism && (r_hist != 5'b00000)) begin
                            // All-zero history is the LFSR lock-up pattern and
                            // would trivially "match" a constant-zero input.
                            if (w_match_inc == c_lock_cnt) begin
                                r_state <= ST_LOCKED;
                                locked  <= 1'b1;
                                r_match <= 8'd0;
                                r_wcnt  <= '0;
                                r_werr  <= '0;
                            end else begin
                                r_match <= w_match_inc;
                            end
                        end else begin
                            r_match <= 8'd0;
                        end
                    end

                    ST_LOCKED: begin
                        // Flywheel: feed back the prediction, not the received
                        // bit, so a corrupted bit never poisons the history.
                        r_hist <= {r_hist[3:0], w_pred};
                        if (bit_cnt != c_cnt_max) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (w_mism) begin
                            err_pulse <= 1'b1;
                            if (err_cnt != c_cnt_max) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end

                        // The error on the window's last bit still belongs to
                        // that window, so the limit is tested before the wrap.
                        if (w_werr_inc >= c_err_limit) begin
                            r_state <= ST_SEARCH;
                            locked  <= 1'b0;
                            r_fill  <= 3'd0;
                            r_match <= 8'd0;
                            r_wcnt  <= '0;
                            r_werr  <= '0;
                        end else if (r_wcnt == c_win_last) begin
                            r_wcnt  <= '0;
                            r_werr  <= '0;
                        end else begin
                            r_wcnt  <= r_wcnt + 1'b1;
                            r_werr  <= w_werr_inc;
                        end
                    end

                    default: begin
                        r_state <= ST_SEARCH;
                        locked  <= 1'b0;
                    end
                endcase
            end

            // Clear takes priority over a same-edge increment; err_pulse is
            // deliberately left as computed above.
            if (clr_cnt) begin
                err_cnt <= '0;
                bit_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prbs5_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs5_checker
// Description : Self-checking bench for prbs5_checker. A second instance with
//               4-bit counters exercises saturation. Expected values come from
//               a reference model that tracks the stream phase in a period-31
//               table built from y(n) = y(n-3) ^ y(n-5).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs5_checker;

    localparam int LOCK_CNT  = 8;
    localparam int ERR_LIMIT = 4;
    localparam int WIN       = 31;
    localparam int CNT_W     = 16;
    localparam int CNT_MAX   = 65535;
    localparam int SMALL_MAX = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_cnt, bit_cnt;
    logic        locked_s, err_pulse_s;
    logic [3:0]  err_cnt_s, bit_cnt_s;

    prbs5_checker #(
        .LOCK_CNT (LOCK_CNT),
        .ERR_LIMIT(ERR_LIMIT),
        .WIN      (WIN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .clr_cnt  (clr_cnt),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt),
        .bit_cnt  (bit_cnt)
    );

    prbs5_checker #(
        .LOCK_CNT (LOCK_CNT),
        .ERR_LIMIT(ERR_LIMIT),
        .WIN      (WIN),
        .CNT_W    (4)
    ) dut_small (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .clr_cnt  (clr_cnt),
        .locked   (locked_s),
        .err_pulse(err_pulse_s),
        .err_cnt  (err_cnt_s),
        .bit_cnt  (bit_cnt_s)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Period-31 reference sequence and generator phase.
    int seq[31];
    int g = 0;

    // Reference model state.
    int m_locked, m_fill, m_match, m_phase, m_wpos, m_werr, m_pulse;
    int m_err, m_bit, m_err_s, m_bit_s;
    bit m_hist[$];   // m_hist[k] = y(n-1-k)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_fill = 0; m_match = 0; m_phase = 0;
        m_wpos = 0; m_werr = 0; m_pulse = 0;
        m_err = 0; m_bit = 0; m_err_s = 0; m_bit_s = 0;
        m_hist.delete();
    endtask

    // Locate the stream phase that follows the last five received bits.
    function automatic int find_phase();
        for (int i = 0; i < 31; i++) begin
            bit ok = 1'b1;
            for (int k = 0; k < 5; k++)
                if (seq[(i + k) % 31] != int'(m_hist[4 - k])) ok = 1'b0;
            if (ok) return (i + 5) % 31;
        end
        return 0;
    endfunction

    task automatic model_update(input bit b, input bit v, input bit c);
        m_pulse = 0;
        if (v) begin
            if (m_locked == 0) begin
                if (m_fill < 5) begin
                    m_fill++;
                end else begin
                    bit p  = m_hist[2] ^ m_hist[4];
                    bit nz = m_hist[0] | m_hist[1] | m_hist[2] | m_hist[3] | m_hist[4];
                    if (b == p && nz) m_match++;
                    else              m_match = 0;
                end
                m_hist.push_front(b);
                if (m_hist.size() > 5) void'(m_hist.pop_back());
                if (m_match == LOCK_CNT) begin
                    m_locked = 1; m_match = 0; m_wpos = 0; m_werr = 0;
                    m_phase = find_phase();
                end
            end else begin
                int e = seq[m_phase];
                m_phase = (m_phase + 1) % 31;
                if (m_bit < CNT_MAX)   m_bit++;
                if (m_bit_s < SMALL_MAX) m_bit_s++;
                if (int'(b) != e) begin
                    m_pulse = 1;
                    if (m_err < CNT_MAX)   m_err++;
                    if (m_err_s < SMALL_MAX) m_err_s++;
                    m_werr++;
                end
                m_wpos++;
                if (m_werr >= ERR_LIMIT) begin
                    m_locked = 0; m_fill = 0; m_match = 0;
                    m_wpos = 0; m_werr = 0;
                    m_hist.delete();
                end else if (m_wpos == WIN) begin
                    m_wpos = 0; m_werr = 0;
                end
            end
        end
        if (c) begin
            m_err = 0; m_bit = 0; m_err_s = 0; m_bit_s = 0;
        end
    endtask

    task automatic compare_all();
        chk("locked",      32'(locked),      32'(m_locked));
        chk("err_pulse",   32'(err_pulse),   32'(m_pulse));
        chk("err_cnt",     32'(err_cnt),     32'(m_err));
        chk("bit_cnt",     32'(bit_cnt),     32'(m_bit));
        chk("err_cnt_sat", 32'(err_cnt_s),   32'(m_err_s));
        chk("bit_cnt_sat", 32'(bit_cnt_s),   32'(m_bit_s));
    endtask

    // One clock edge with raw inputs; sample 1 time unit after the edge.
    task automatic step(input bit b, input bit v, input bit c);
        bit_in = b; bit_valid = v; clr_cnt = c;
        @(posedge clk);
        #1;
        model_update(b, v, c);
        compare_all();
    endtask

    // One edge driven from the generator, optionally inverting the bit.
    task automatic send(input bit flip, input bit v, input bit c);
        bit b;
        if (v) begin
            b = bit'(seq[g]) ^ flip;
            g = (g + 1) % 31;
        end else begin
            b = bit'($urandom_range(0, 1));
        end
        step(b, v, c);
    endtask

    task automatic do_reset(input int start_phase);
        rst = 1'b1;
        bit_valid = 1'b0; clr_cnt = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        g = start_phase;
    endtask

    initial begin
        for (int n = 0; n < 5; n++) seq[n] = 1;
        for (int n = 5; n < 31; n++) seq[n] = seq[n - 3] ^ seq[n - 5];
        model_reset();

        // 1: reset, clean stream, lock after 13 bits, then 62 counted bits
        repeat (2) @(posedge clk);
        do_reset(0);
        for (int i = 0; i < 12; i++) send(0, 1, 0);
        chk("t1_unlocked_at_12", 32'(locked), 32'd0);
        send(0, 1, 0);
        chk("t1_locked_at_13", 32'(locked), 32'd1);
        for (int i = 0; i < 62; i++) send(0, 1, 0);
        chk("t1_bit_cnt_62", 32'(bit_cnt), 32'd62);
        chk("t1_err_cnt_0",  32'(err_cnt), 32'd0);

        // 2: single flipped bit
        send(0, 1, 1);
        send(1, 1, 0);
        chk("t2_pulse_high", 32'(err_pulse), 32'd1);
        send(0, 1, 0);
        chk("t2_pulse_one_cycle", 32'(err_pulse), 32'd0);
        for (int i = 0; i < 40; i++) send(0, 1, 0);
        chk("t2_err_cnt_1", 32'(err_cnt), 32'd1);
        chk("t2_still_locked", 32'(locked), 32'd1);

        // 3: four errors inside one window -> lose lock, then relock
        send(0, 1, 1);
        for (int i = 0; i < 40 && m_wpos != 0; i++) send(0, 1, 0);
        for (int i = 0; i < 4; i++) send(1, 1, 0);
        chk("t3_lock_lost", 32'(locked), 32'd0);
        chk("t3_err_cnt_4", 32'(err_cnt), 32'd4);
        for (int i = 0; i < 12; i++) send(0, 1, 0);
        chk("t3_not_yet_relocked", 32'(locked), 32'd0);
        send(0, 1, 0);
        chk("t3_relocked", 32'(locked), 32'd1);
        chk("t3_err_cnt_kept", 32'(err_cnt), 32'd4);

        // 4: three errors at end of one window, one in the next -> keep lock
        send(0, 1, 1);
        for (int i = 0; i < 40 && m_wpos != 28; i++) send(0, 1, 0);
        for (int i = 0; i < 3; i++) send(1, 1, 0);
        send(0, 1, 0);
        send(0, 1, 0);
        send(1, 1, 0);
        for (int i = 0; i < 10; i++) send(0, 1, 0);
        chk("t4_still_locked", 32'(locked), 32'd1);
        chk("t4_err_cnt_4", 32'(err_cnt), 32'd4);

        // 5: constant zero never locks
        do_reset(0);
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b0);
        chk("t5_never_locked", 32'(locked), 32'd0);
        chk("t5_err_cnt_0", 32'(err_cnt), 32'd0);
        chk("t5_bit_cnt_0", 32'(bit_cnt), 32'd0);

        // 6: gapped stream, clear coinciding with an error
        do_reset(7);
        for (int i = 0; i < 13; i++) send(0, 1, 0);
        for (int i = 0; i < 30; i++) send(0, i % 2 == 0, 0);
        chk("t6_gaps_keep_lock", 32'(locked), 32'd1);
        send(1, 1, 1);
        chk("t6_clr_pulse", 32'(err_pulse), 32'd1);
        chk("t6_clr_err_cnt", 32'(err_cnt), 32'd0);
        chk("t6_clr_bit_cnt", 32'(bit_cnt), 32'd0);
        send(0, 0, 0);
        chk("t6_gap_no_pulse", 32'(err_pulse), 32'd0);
        send(0, 1, 0);
        chk("t6_resume_bit_cnt", 32'(bit_cnt), 32'd1);

        // 7: randomized gaps, flips, clears and one mid-stream reset
        for (int i = 0; i < 700; i++) begin
            bit v, f, c;
            if (i == 350) do_reset(int'($urandom_range(0, 30)));
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 149) == 0);
            send(f, v, c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
